// File: rtl/fifo_rr_arbiter.sv
// Round-robin drain of NUM_SRC show-ahead FIFOs into one registered, source-tagged
// output stream, with at most MAX_BURST words per grant.
module fifo_rr_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int WIDTH     = 8,
  parameter int SRC_W     = 2,
  parameter int MAX_BURST = 4,
  parameter int BURST_W   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NUM_SRC-1:0]       src_empty,
  input  logic [NUM_SRC*WIDTH-1:0] src_q,
  output logic [NUM_SRC-1:0]       src_rdreq,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [SRC_W-1:0]         out_src,
  input  logic                     out_ready,
  output logic                     grant_valid,
  output logic [SRC_W-1:0]         grant_id
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t             state_r, state_nxt_s;
  logic [SRC_W-1:0]   grant_id_r, last_ptr_r, winner_s;
  logic               winner_found_s;
  logic [BURST_W-1:0] burst_cnt_r;
  logic               out_valid_r;
  logic [WIDTH-1:0]   out_data_r, head_s;
  logic [SRC_W-1:0]   out_src_r;
  logic               pop_s, head_empty_s, burst_last_s;
  logic [NUM_SRC-1:0] src_rdreq_s;

  // First non-empty source after 'last', wrapping; MSB flags that one exists.
  function automatic logic [SRC_W:0] pick_next(input logic [NUM_SRC-1:0] empty,
                                               input logic [SRC_W-1:0]   last);
    logic [SRC_W:0] res;
    int             idx;
    res = {1'b0, {SRC_W{1'b0}}};
    // Descending scan so the nearest candidate is the last one written.
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_SRC;
      if (!empty[idx[SRC_W-1:0]]) res = {1'b1, idx[SRC_W-1:0]};
    end
    return res;
  endfunction

  // Pop qualification, arbitration result and one-hot read strobe.
  always_comb begin
    {winner_found_s, winner_s} = pick_next(src_empty, last_ptr_r);
    head_empty_s = src_empty[grant_id_r];
    head_s       = src_q[int'(grant_id_r)*WIDTH +: WIDTH];
    burst_last_s = (burst_cnt_r == BURST_W'(MAX_BURST - 1));
    pop_s        = !rst && (state_r == GRANT) && !head_empty_s && (!out_valid_r || out_ready);
    src_rdreq_s  = {NUM_SRC{1'b0}};
    if (pop_s) begin
      src_rdreq_s[grant_id_r] = 1'b1;
    end else begin
      src_rdreq_s = {NUM_SRC{1'b0}};
    end
  end

  // Next-state logic for the IDLE/GRANT controller.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (en && winner_found_s) state_nxt_s = GRANT;
        else                      state_nxt_s = IDLE;
      end
      GRANT: begin
        if (head_empty_s || (pop_s && burst_last_s)) state_nxt_s = IDLE;
        else                                         state_nxt_s = GRANT;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, grant bookkeeping and the registered output word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      grant_id_r  <= {SRC_W{1'b0}};
      last_ptr_r  <= SRC_W'(NUM_SRC - 1);
      burst_cnt_r <= {BURST_W{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
      out_src_r   <= {SRC_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == IDLE) && (state_nxt_s == GRANT)) begin
        grant_id_r  <= winner_s;
        last_ptr_r  <= winner_s;
        burst_cnt_r <= {BURST_W{1'b0}};
      end else if (pop_s) begin
        burst_cnt_r <= burst_cnt_r + BURST_W'(1);
      end
      if (pop_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= head_s;
        out_src_r   <= grant_id_r;
      end else if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign src_rdreq   = src_rdreq_s;
  assign out_valid   = out_valid_r;
  assign out_data    = out_data_r;
  assign out_src     = out_src_r;
  assign grant_valid = (state_r == GRANT);
  assign grant_id    = grant_id_r;

endmodule
